instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the multi-cycle controller.
- Holds the PC, issues requests to instruction memory over a req/ack handshake, and latches the returned word into the instruction register.
- Drives the 6-bit opcode that is the controller's input_signal.
- Applies PC updates (sequential, branch, jump) commanded by the controller, and bounds memory wait states with a timeout.

Parameters:
- ADDR_WIDTH, 16: PC / instruction address width (word addressed).
- INSTR_WIDTH, 32: instruction word width.
- OPCODE_WIDTH, 6: opcode width; opcode = instr[INSTR_WIDTH-1 -: OPCODE_WIDTH].
- TIMEOUT, 15: max FETCH cycles without ack before error (1..255).
- RESET_PC, 0: PC value after reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- fetch_en  in  1  controller request to fetch at current PC.
- pc_write  in  1  controller request to update PC.
- pc_src  in  2  PC update select: 00 pc+1, 01 pc+branch_offset, 10 jump_target, 11 hold.
- branch_offset  in  ADDR_WIDTH  two's-complement offset.
- jump_target  in  ADDR_WIDTH  absolute jump address.
- imem_req  out  1  memory request.
- imem_addr  out  ADDR_WIDTH  memory address.
- imem_ack  in  1  memory data valid.
- imem_rdata  in  INSTR_WIDTH  memory read data.
- instr  out  INSTR_WIDTH  instruction register.
- opcode  out  OPCODE_WIDTH  top bits of instr, to controller.
- pc  out  ADDR_WIDTH  current PC.
- instr_valid  out  1  one-cycle pulse: instr updated.
- busy  out  1  high in FETCH and DONE.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- Reset (reset=0, asynchronous, any state): state=IDLE, pc=RESET_PC, instr=0, opcode=0, imem_req=0, imem_addr=0, instr_valid=0, busy=0, fetch_err=0, timeout counter=0.

States:
- IDLE:
  - fetch_en=1 -> FETCH; fetch_err clears; counter clears.
  - pc_write=1 applies pc_src at the same edge.
  - If fetch_en and pc_write are both high, PC updates at that edge and the fetch uses the new PC.
- FETCH:
  - imem_req=1 and imem_addr=pc, both registered and stable for the whole state.
  - imem_ack=1 at an edge -> instr<=imem_rdata, pc<=pc+1, state->DONE.
  - Otherwise the counter increments; on the edge where the counter reaches TIMEOUT -> instr<=0, pc unchanged, fetch_err<=1, state->DONE.
- DONE: instr_valid=1, imem_req=0; unconditional return to IDLE next edge.

Handshake and arithmetic rules:
- imem_ack outside FETCH is ignored.
- fetch_en and pc_write are ignored outside IDLE.
- Minimum latency: fetch_en edge -> instr_valid high 2 cycles later (ack in the first FETCH cycle).
- PC arithmetic is modulo 2^ADDR_WIDTH (wraps: 0xFFFF+1=0x0000). Branch addition is modular.
- Branch is relative to the already-incremented PC.
- opcode always equals instr's top OPCODE_WIDTH bits. Timeout yields opcode 000000.
- Reset mid-FETCH drops imem_req immediately. A late ack after reset is ignored.

Decomposition:
- Shared package: fetch FSM state encoding (IDLE=2'b00, FETCH=2'b01, DONE=2'b10), pc_src codes (PC_SEQ, PC_BRANCH, PC_JUMP, PC_HOLD), default widths.
- One natural sub-module: pc_next_logic, a combinational PC mux/adder (pc, pc_src, branch_offset, jump_target -> pc_next).
- FSM, counter and instruction register stay in instr_fetch_unit.

Test Plan:
- Reset, then fetch_en with memory returning 0x40000000 after 1 cycle -> imem_addr=0x0000, instr_valid pulse 2 cycles after fetch_en, opcode=010000, pc=0x0001.
- Ack delayed 5 cycles with rdata 0xC4000000 -> imem_req held 6 cycles with stable addr, busy high throughout, opcode=110001, fetch_err=0.
- pc=0x0010, pc_write pc_src=01 branch_offset=0xFFFC -> pc=0x000C; pc_src=10 jump_target=0x1234 -> pc=0x1234; pc_src=11 -> unchanged; pc=0xFFFF fetch -> pc=0x0000.
- No ack for TIMEOUT=15 cycles -> fetch_err=1, opcode=000000, pc unchanged, instr_valid pulse. Next fetch_en clears fetch_err.
- reset asserted mid-FETCH -> imem_req=0 and pc=RESET_PC without a clock edge; ack pulse right after reset release -> no instr_valid.
- fetch_en and pc_write (pc_src=10, jump_target=0x0040) on the same edge -> imem_addr=0x0040. fetch_en during FETCH -> ignored, single instr_valid.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : fetch FSM encoding (IDLE / FETCH / DONE)
//   pc_src_e      : PC update select codes driven by the controller
//   *_DEF         : default widths / limits used as parameter defaults
package instr_fetch_unit_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int INSTR_W_DEF = 32;
    localparam int OPC_W_DEF   = 6;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        DONE  = 2'b10
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_HOLD   = 2'b11
    } pc_src_e;

endpackage

// File: rtl/instr_fetch_unit_pc_next_logic.sv
// pc_next_logic: combinational next-PC selector.
//   pc            in  current PC
//   pc_src        in  00 pc+1, 01 pc+branch_offset, 10 jump_target, 11 hold
//   branch_offset in  two's-complement offset (modular add)
//   jump_target   in  absolute target
//   pc_next       out selected next PC
module pc_next_logic
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W_DEF
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [1:0]            pc_src,
    input  logic [ADDR_WIDTH-1:0] branch_offset,
    input  logic [ADDR_WIDTH-1:0] jump_target,
    output logic [ADDR_WIDTH-1:0] pc_next
);

    // Sums are truncated to ADDR_WIDTH, so all arithmetic wraps.
    always_comb begin
        pc_next = pc;
        case (pc_src)
            PC_SEQ:    pc_next = pc + ADDR_WIDTH'(1);
            PC_BRANCH: pc_next = pc + branch_offset;
            PC_JUMP:   pc_next = jump_target;
            default:   pc_next = pc;
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage ahead of the multi-cycle controller.
// Holds the PC, fetches one word per fetch_en over a req/ack handshake,
// latches it into the instruction register and exposes its opcode.
//   clk, reset (async, active low)
//   fetch_en, pc_write, pc_src, branch_offset, jump_target : controller
//   imem_req, imem_addr, imem_ack, imem_rdata             : instruction memory
//   instr, opcode, pc, instr_valid, busy, fetch_err       : status / results
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = ADDR_W_DEF,
    parameter int                    INSTR_WIDTH  = INSTR_W_DEF,
    parameter int                    OPCODE_WIDTH = OPC_W_DEF,
    parameter int                    TIMEOUT      = TIMEOUT_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fetch_en,
    input  logic                    pc_write,
    input  logic [1:0]              pc_src,
    input  logic [ADDR_WIDTH-1:0]   branch_offset,
    input  logic [ADDR_WIDTH-1:0]   jump_target,
    output logic                    imem_req,
    output logic [ADDR_WIDTH-1:0]   imem_addr,
    input  logic                    imem_ack,
    input  logic [INSTR_WIDTH-1:0]  imem_rdata,
    output logic [INSTR_WIDTH-1:0]  instr,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic [ADDR_WIDTH-1:0]   pc,
    output logic                    instr_valid,
    output logic                    busy,
    output logic                    fetch_err
);

    localparam int CNT_W = 8;

    fetch_state_e          state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [1:0]            pc_sel;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  timeout_hit;

    // In FETCH the only PC update is the post-ack increment, so the mux is
    // forced to sequential there. A later branch is then relative to the
    // already-incremented PC held in the register.
    assign pc_sel = (state == FETCH) ? PC_SEQ : pc_src;

    pc_next_logic #(.ADDR_WIDTH(ADDR_WIDTH)) u_pc_next (
        .pc            (pc),
        .pc_src        (pc_sel),
        .branch_offset (branch_offset),
        .jump_target   (jump_target),
        .pc_next       (pc_next)
    );

    // True on the edge where this wait cycle brings the counter to TIMEOUT.
    assign timeout_hit = (cnt + CNT_W'(1)) == CNT_W'(TIMEOUT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fetch_en) state_nxt = FETCH;
            FETCH:   if (imem_ack || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= RESET_PC;
            instr     <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            fetch_err <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_write) pc <= pc_next;
                    if (fetch_en) begin
                        // Simultaneous pc_write: fetch from the updated PC.
                        imem_req  <= 1'b1;
                        imem_addr <= pc_write ? pc_next : pc;
                        fetch_err <= 1'b0;
                        cnt       <= '0;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        instr    <= imem_rdata;
                        pc       <= pc_next;
                        imem_req <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (timeout_hit) begin
                            instr     <= '0;
                            fetch_err <= 1'b1;
                            imem_req  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_valid = (state == DONE);
    assign busy        = (state != IDLE);
    assign opcode      = instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int AW = 16;
    localparam int IW = 32;
    localparam int OW = 6;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fetch_en = 1'b0;
    logic          pc_write = 1'b0;
    logic [1:0]    pc_src = 2'b00;
    logic [AW-1:0] branch_offset = '0;
    logic [AW-1:0] jump_target = '0;
    logic          imem_ack = 1'b0;
    logic [IW-1:0] imem_rdata = '0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] instr;
    logic [OW-1:0] opcode;
    logic [AW-1:0] pc;
    logic          instr_valid, busy, fetch_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .OPCODE_WIDTH(OW),
        .TIMEOUT(TO), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_write(pc_write),
        .pc_src(pc_src), .branch_offset(branch_offset), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode), .pc(pc),
        .instr_valid(instr_valid), .busy(busy), .fetch_err(fetch_err)
    );

    // Behavioural model: mode 0 = ready for a request, 1 = waiting on memory,
    // 2 = result being reported for one cycle.
    int            m_mode;
    int            m_wait;
    logic [AW-1:0] m_pc, m_addr;
    logic [IW-1:0] m_instr;
    logic          m_err;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_wait = 0; m_pc = '0; m_addr = '0; m_instr = '0; m_err = 1'b0;
        end else if (m_mode == 0) begin
            if (pc_write) begin
                if (pc_src == 2'd0)      m_pc = m_pc + 1;
                else if (pc_src == 2'd1) m_pc = m_pc + branch_offset;
                else if (pc_src == 2'd2) m_pc = jump_target;
            end
            if (fetch_en) begin
                m_mode = 1; m_addr = m_pc; m_err = 1'b0; m_wait = 0;
            end
        end else if (m_mode == 1) begin
            if (imem_ack) begin
                m_instr = imem_rdata; m_pc = m_pc + 1; m_mode = 2;
            end else begin
                m_wait = m_wait + 1;
                if (m_wait >= TO) begin
                    m_instr = '0; m_err = 1'b1; m_mode = 2;
                end
            end
        end else begin
            m_mode = 0;
        end
    end

    logic cmp_ok;
    always @(negedge clk) begin
        cmp_ok = (imem_req === (m_mode == 1)) && (busy === (m_mode != 0)) &&
                 (instr_valid === (m_mode == 2)) && (pc === m_pc) &&
                 (instr === m_instr) && (opcode === m_instr[IW-1 -: OW]) &&
                 (fetch_err === m_err) && (m_mode != 1 || imem_addr === m_addr);
        n_chk++;
        if (cmp_ok) n_pass++;
        else $display("FAIL model t=%0t got req=%b addr=%h instr=%h op=%b pc=%h vld=%b busy=%b err=%b exp mode=%0d addr=%h instr=%h pc=%h err=%b",
                      $time, imem_req, imem_addr, instr, opcode, pc, instr_valid, busy, fetch_err,
                      m_mode, m_addr, m_instr, m_pc, m_err);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic pc_upd(input logic [1:0] s, input logic [AW-1:0] off, input logic [AW-1:0] jt);
        pc_write = 1'b1; pc_src = s; branch_offset = off; jump_target = jt;
        @(negedge clk);
        pc_write = 1'b0;
    endtask

    // Issue a fetch, ack after dly wait cycles; returns in the reporting cycle.
    task automatic fetch(input logic [IW-1:0] data, input int dly, output int rc,
                         output logic [AW-1:0] a0, output bit stable, output bit bsy);
        fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0;
        rc = 0; a0 = imem_addr; stable = 1'b1; bsy = 1'b1;
        for (int i = 0; i <= dly; i++) begin
            if (imem_req) rc++;
            if (imem_addr !== a0) stable = 1'b0;
            if (!busy) bsy = 1'b0;
            if (i == dly) begin imem_ack = 1'b1; imem_rdata = data; end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        if (!busy) bsy = 1'b0;
    endtask

    initial begin
        int            rc, pulses;
        logic [AW-1:0] a0;
        bit            stable, bsy;

        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_instr", instr, 32'h0);
        chk("rst_opcode", opcode, 6'b0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_flags", {instr_valid, busy, fetch_err}, 3'b000);
        reset = 1'b1;
        @(negedge clk);

        // single-cycle ack
        fetch(32'h4000_0000, 0, rc, a0, stable, bsy);
        chk("f1_addr", a0, 16'h0000);
        chk("f1_valid", instr_valid, 1'b1);
        chk("f1_opcode", opcode, 6'b010000);
        chk("f1_pc", pc, 16'h0001);
        chk("f1_req_cycles", rc, 1);
        @(negedge clk);
        chk("f1_valid_drop", instr_valid, 1'b0);

        // ack after 5 wait cycles
        fetch(32'hC400_0000, 5, rc, a0, stable, bsy);
        chk("f2_req_cycles", rc, 6);
        chk("f2_addr_stable", stable, 1'b1);
        chk("f2_busy", bsy, 1'b1);
        chk("f2_opcode", opcode, 6'b110001);
        chk("f2_err", fetch_err, 1'b0);
        chk("f2_pc", pc, 16'h0002);
        @(negedge clk);

        // PC updates
        pc_upd(2'b10, '0, 16'h0010);       chk("pc_jmp10", pc, 16'h0010);
        pc_upd(2'b01, 16'hFFFC, '0);       chk("pc_branch", pc, 16'h000C);
        pc_upd(2'b10, '0, 16'h1234);       chk("pc_jump", pc, 16'h1234);
        pc_upd(2'b11, 16'h0005, 16'h0777); chk("pc_hold", pc, 16'h1234);
        pc_upd(2'b00, '0, '0);             chk("pc_seq", pc, 16'h1235);
        pc_upd(2'b10, '0, 16'hFFFF);
        fetch(32'h0800_0000, 0, rc, a0, stable, bsy);
        chk("wrap_addr", a0, 16'hFFFF);
        chk("wrap_pc", pc, 16'h0000);
        @(negedge clk);

        // timeout
        pc_upd(2'b10, '0, 16'h0100);
        fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0;
        repeat (TO - 1) @(negedge clk);
        chk("to_not_yet", instr_valid, 1'b0);
        @(negedge clk);
        chk("to_valid", instr_valid, 1'b1);
        chk("to_err", fetch_err, 1'b1);
        chk("to_opcode", opcode, 6'b000000);
        chk("to_instr", instr, 32'h0);
        chk("to_pc", pc, 16'h0100);
        @(negedge clk);
        chk("to_sticky", fetch_err, 1'b1);
        fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0;
        chk("to_err_clear", fetch_err, 1'b0);
        imem_ack = 1'b1; imem_rdata = 32'h1000_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("to_refetch_pc", pc, 16'h0101);
        @(negedge clk);

        // reset in the middle of a fetch
        fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0;
        chk("mid_req_before", imem_req, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("mid_req_async", imem_req, 1'b0);
        chk("mid_pc_async", pc, 16'h0000);
        chk("mid_busy_async", busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'hFC00_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (instr_valid) pulses++;
            @(negedge clk);
        end
        chk("late_ack_pulses", pulses, 0);
        chk("late_ack_opcode", opcode, 6'b0);

        // fetch_en + pc_write together, then fetch_en held into FETCH
        fetch_en = 1'b1; pc_write = 1'b1; pc_src = 2'b10; jump_target = 16'h0040;
        @(negedge clk);
        pc_write = 1'b0;
        chk("same_edge_addr", imem_addr, 16'h0040);
        chk("same_edge_pc", pc, 16'h0040);
        @(negedge clk);
        fetch_en = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h2000_0000;
        @(negedge clk);
        imem_ack = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (instr_valid) pulses++;
            @(negedge clk);
        end
        chk("single_pulse", pulses, 1);
        chk("same_edge_pc_after", pc, 16'h0041);
        chk("same_edge_opcode", opcode, 6'b001000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
